// File: rtl/semafor_pkg.sv
// Shared types for the semafor traffic-light controller: mode word encoding,
// mode sequencing helper and lamp colour constants.
package semafor_pkg;

  typedef enum logic [1:0] {
    SEL_NORMAL = 2'b00,
    SEL_A_PRIO = 2'b01,
    SEL_B_PRIO = 2'b10,
    SEL_NIGHT  = 2'b11
  } sel_mode_t;

  // Lamp drive words {red, amber, green} used by the semafor block.
  localparam logic [2:0] LAMP_OFF   = 3'b000;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;

  function automatic sel_mode_t next_mode(input sel_mode_t mode);
    case (mode)
      SEL_NORMAL: return SEL_A_PRIO;
      SEL_A_PRIO: return SEL_B_PRIO;
      default:    return SEL_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debouncer and a
// one-cycle pulse on each accepted rising edge.
module sel_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // NOTE: all state here is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (the synchroniser
  // chain depends on it).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_MAX) begin
        // Level accepted; only the low-to-high transition is a press.
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/semafor_sel_ctrl.sv
// Mode-word generator for semafor Sel_in: debounced next/night buttons,
// minimum dwell between changes with a one-deep deferred request.
module semafor_sel_ctrl
  import semafor_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int MIN_DWELL  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_next,
  input  logic       btn_night,
  output logic [1:0] Sel_out,
  output logic       sel_changed,
  output logic       dwell_busy,
  output logic       req_pending
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);

  logic          w_next_press;
  logic          w_night_press;
  logic          w_apply_pending;

  sel_mode_t     r_sel;
  sel_mode_t     r_saved;
  logic          r_night;
  logic          r_pending;
  logic          r_changed;
  logic [DW-1:0] r_dwell;

  sel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (btn_next),
    .o_press (w_next_press)
  );

  sel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_night (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (btn_night),
    .o_press (w_night_press)
  );

  // Apply on the 1->0 step of the dwell counter; also at 0 so a request
  // deferred in the very last busy cycle is still honoured one edge later.
  assign w_apply_pending = r_pending && (r_dwell < DW'(2));

  // NOTE: reset is asynchronous so outputs clear the instant reset_n falls,
  // independent of the clock; r_changed resets low so release is silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel     <= SEL_NORMAL;
      r_saved   <= SEL_NORMAL;
      r_night   <= 1'b0;
      r_pending <= 1'b0;
      r_changed <= 1'b0;
      r_dwell   <= '0;
    end else begin
      r_changed <= 1'b0;
      if (r_dwell != '0) r_dwell <= r_dwell - DW'(1);

      if (w_night_press) begin
        // Night wins over any same-cycle next press and ignores the dwell.
        if (!r_night) begin
          r_saved   <= r_sel;
          r_sel     <= SEL_NIGHT;
          r_pending <= 1'b0;
          r_night   <= 1'b1;
        end else begin
          r_sel   <= r_saved;
          r_night <= 1'b0;
        end
        r_changed <= 1'b1;
        r_dwell   <= DWELL_LOAD;
      end else if (w_apply_pending) begin
        r_sel     <= next_mode(r_sel);
        r_pending <= 1'b0;
        r_changed <= 1'b1;
        r_dwell   <= DWELL_LOAD;
      end else if (w_next_press && !r_night) begin
        if (r_dwell != '0) begin
          r_pending <= 1'b1;
        end else begin
          r_sel     <= next_mode(r_sel);
          r_changed <= 1'b1;
          r_dwell   <= DWELL_LOAD;
        end
      end
    end
  end

  assign Sel_out     = r_sel;
  assign sel_changed = r_changed;
  assign dwell_busy  = (r_dwell != '0);
  assign req_pending = r_pending;

endmodule
